// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with IF/ID pipeline register.
// Keeps the PC and runs a req/ready handshake to instruction memory.
// It absorbs downstream stalls through a one-entry skid register.
// On a branch redirect it flushes IF/ID and discards any fetch still in flight.
// Optional build macro: IF_MISALIGN_TRAP_EN (adds misalign_err and a HALT state).
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// REQ   | normal fetching from pc
// DROP  | stale request outstanding; its data is discarded on ready
// HALT  | misaligned branch trapped; fetch stopped until reset
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
`ifdef IF_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_func3,
  output logic        id_func7b5
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_DROP, S_HALT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] drop_addr_q;
  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic        skid_valid_q;
  logic [31:0] skid_instr_q;
  logic        pend_q;       // request asserted earlier and not yet completed
  logic        halt_pend_q;  // go to HALT once the outstanding request completes

  logic [31:0] br_tgt;
  logic        br_bad;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q;
  assign br_tgt       = branch_target;
  assign br_bad       = |branch_target[1:0];
  assign misalign_err = misalign_q;
`else
  logic unused_tgt_lsb;
  assign br_tgt         = {branch_target[31:2], 2'b00};
  assign br_bad         = 1'b0;
  assign unused_tgt_lsb = ^branch_target[1:0];
`endif

  // Request/address drive: a started request is held until ready; a full skid blocks new ones
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      S_REQ:   imem_req = pend_q | (~stall & ~skid_valid_q);
      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // Fetch FSM, PC, skid and IF/ID register; priority branch > stall > capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      pend_q       <= 1'b0;
      halt_pend_q  <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_BOOT: state_q <= S_REQ;
        S_REQ: begin
          if (branch_taken) begin
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            skid_valid_q <= 1'b0;
            pend_q       <= 1'b0;
            drop_addr_q  <= pc_q;
            if (br_bad) begin
`ifdef IF_MISALIGN_TRAP_EN
              misalign_q  <= 1'b1;
`endif
              halt_pend_q <= 1'b1;
              state_q     <= (imem_req && !imem_ready) ? S_DROP : S_HALT;
            end else begin
              pc_q <= br_tgt;
              if (imem_req && !imem_ready) state_q <= S_DROP;
            end
          end else if (stall) begin
            if (imem_req && imem_ready) begin
              skid_valid_q <= 1'b1;
              skid_instr_q <= imem_rdata;
              pend_q       <= 1'b0;
            end else begin
              pend_q <= imem_req;
            end
          end else if (skid_valid_q) begin
            id_valid_q   <= 1'b1;
            id_instr_q   <= skid_instr_q;
            id_pc_q      <= pc_q;
            pc_q         <= pc_q + 32'd4;
            skid_valid_q <= 1'b0;
          end else if (imem_req && imem_ready) begin
            id_valid_q <= 1'b1;
            id_instr_q <= imem_rdata;
            id_pc_q    <= pc_q;
            pc_q       <= pc_q + 32'd4;
            pend_q     <= 1'b0;
          end else begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            pend_q     <= imem_req;
          end
        end
        S_DROP: begin
          if (branch_taken) begin
            if (br_bad) begin
`ifdef IF_MISALIGN_TRAP_EN
              misalign_q  <= 1'b1;
`endif
              halt_pend_q <= 1'b1;
            end else begin
              pc_q <= br_tgt;
            end
          end
          if (imem_ready)
            state_q <= (halt_pend_q || (branch_taken && br_bad)) ? S_HALT : S_REQ;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign id_valid   = id_valid_q;
  assign id_instr   = id_instr_q;
  assign id_pc      = id_pc_q;
  assign id_opcode  = id_instr_q[6:0];
  assign id_func3   = id_instr_q[14:12];
  assign id_func7b5 = id_instr_q[30];

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table, hand sequences and randomized run for if_stage.
module tb_if_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] GARB = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_func3;
  logic        id_func7b5;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
`ifdef IF_MISALIGN_TRAP_EN
    .misalign_err  (misalign_err),
`endif
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_opcode     (id_opcode),
    .id_func3      (id_func3),
    .id_func7b5    (id_func7b5)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_id(input string tag, input logic ev, input logic [31:0] ei,
                          input logic [31:0] ep);
    chk({tag, ".id_valid"},   32'(id_valid),   32'(ev));
    chk({tag, ".id_instr"},   id_instr,        ei);
    chk({tag, ".id_opcode"},  32'(id_opcode),  32'(ei[6:0]));
    chk({tag, ".id_func3"},   32'(id_func3),   32'(ei[14:12]));
    chk({tag, ".id_func7b5"}, 32'(id_func7b5), 32'(ei[30]));
    if (ev) chk({tag, ".id_pc"}, id_pc, ep);
  endtask

  task automatic check_req(input string tag, input logic er, input logic [31:0] ea);
    chk({tag, ".imem_req"}, 32'(imem_req), 32'(er));
    if (er) chk({tag, ".imem_addr"}, imem_addr, ea);
  endtask

  // Drive one cycle's inputs at the current falling edge and let them settle
  task automatic step(input logic s, input logic b, input logic [31:0] t,
                      input logic r, input logic [31:0] d);
    stall = s; branch_taken = b; branch_target = t; imem_ready = r; imem_rdata = d;
    #1;
  endtask

  task automatic add(input logic s, input logic b, input logic [31:0] t, input logic r,
                     input logic [31:0] d, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.rdy = r; v.rdata = d;
    v.e_req = er; v.e_addr = ea; v.e_val = ev; v.e_instr = ei; v.e_pc = ep;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model state: abstract fetch bookkeeping rather than an FSM encoding
  logic        m_boot, m_idv, m_infl, m_drop, m_skid;
  logic [31:0] m_pc, m_idi, m_idpc, m_iaddr, m_skw;

  task automatic model_reset();
    m_boot = 1'b1; m_pc = 32'h0; m_idv = 1'b0; m_idi = NOP; m_idpc = 32'h0;
    m_infl = 1'b0; m_drop = 1'b0; m_iaddr = 32'h0; m_skid = 1'b0; m_skw = NOP;
  endtask

  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W4  = 32'h00A0_0113;
  localparam logic [31:0] W8  = 32'h4020_81B3;
  localparam logic [31:0] W12 = 32'h00C0_A203;
  localparam logic [31:0] WB  = 32'h0FF0_0093;
  localparam logic [31:0] WF  = 32'h0020_8663;

  initial begin
    rst_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //  stall br tgt          rdy rdata | req addr        val instr pc
    add(0, 0, 32'h0,        0, 32'h0, 0, 32'h0,        0, NOP, 32'h0);
    add(0, 0, 32'h0,        1, W0,    1, 32'h0,        0, NOP, 32'h0);
    add(0, 0, 32'h0,        1, W4,    1, 32'h4,        1, W0,  32'h0);
    add(0, 0, 32'h0,        0, GARB,  1, 32'h8,        1, W4,  32'h4);
    add(0, 0, 32'h0,        0, GARB,  1, 32'h8,        0, NOP, 32'h0);
    add(0, 0, 32'h0,        1, W8,    1, 32'h8,        0, NOP, 32'h0);
    add(0, 0, 32'h0,        0, GARB,  1, 32'hC,        1, W8,  32'h8);
    add(1, 0, 32'h0,        1, W12,   1, 32'hC,        0, NOP, 32'h0);
    add(1, 0, 32'h0,        0, GARB,  0, 32'h0,        0, NOP, 32'h0);
    add(1, 0, 32'h0,        0, GARB,  0, 32'h0,        0, NOP, 32'h0);
    add(0, 0, 32'h0,        0, GARB,  0, 32'h0,        0, NOP, 32'h0);
    add(0, 0, 32'h0,        0, GARB,  1, 32'h10,       1, W12, 32'hC);
    add(0, 1, 32'h100,      0, GARB,  1, 32'h10,       0, NOP, 32'h0);
    add(0, 0, 32'h0,        1, GARB,  1, 32'h10,       0, NOP, 32'h0);
    add(0, 0, 32'h0,        1, WB,    1, 32'h100,      0, NOP, 32'h0);
    add(1, 1, 32'h200,      0, GARB,  0, 32'h0,        1, WB,  32'h100);
    add(0, 0, 32'h0,        0, GARB,  1, 32'h200,      0, NOP, 32'h0);
    add(0, 1, 32'hFFFF_FFFC,1, GARB,  1, 32'h200,      0, NOP, 32'h0);
    add(0, 0, 32'h0,        1, WF,    1, 32'hFFFF_FFFC,0, NOP, 32'h0);
    add(0, 0, 32'h0,        0, GARB,  1, 32'h0,        1, WF,  32'hFFFF_FFFC);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].rdy, tbl[i].rdata);
      check_req(tag, tbl[i].e_req, tbl[i].e_addr);
      check_id(tag, tbl[i].e_val, tbl[i].e_instr, tbl[i].e_pc);
      @(negedge clk);
    end

    // Reset while the fetch at address 0 is still outstanding
    rst_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0, GARB);
    check_req("rst_inflight_pre", 1'b1, 32'h0);
    @(negedge clk);
    step(1'b0, 1'b0, 32'h0, 1'b0, GARB);
    check_req("rst_inflight", 1'b0, 32'h0);
    check_id("rst_inflight", 1'b0, NOP, 32'h0);
    chk("rst_inflight.id_pc", id_pc, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b0, 32'h0, 1'b0, GARB);
    check_req("rst_release", 1'b1, 32'h0);
    @(negedge clk);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    begin
      int wcnt;
      wcnt = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        logic        e_req, rdy;
        logic [31:0] e_addr, rd, tgt;
        rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
        tgt = ($urandom_range(0, 3) == 0) ? {28'hFFF_FFFF, 4'($urandom)} : $urandom;
`ifdef IF_MISALIGN_TRAP_EN
        tgt[1:0] = 2'b00;
`endif
        stall         = ($urandom_range(0, 3) == 0);
        branch_taken  = ($urandom_range(0, 11) == 0);
        branch_target = tgt;
        imem_ready    = 1'b0;
        imem_rdata    = $urandom;
        #1;
        if (imem_req) begin
          if (wcnt == 0) begin
            imem_ready = 1'b1;
            imem_rdata = mem_word(imem_addr);
            wcnt = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
          end else begin
            wcnt--;
          end
        end
        #1;
        e_req  = !m_boot && (m_infl || (!stall && !m_skid));
        e_addr = m_infl ? m_iaddr : m_pc;
        check_req("rand", e_req, e_addr);
        check_id("rand", m_idv, m_idi, m_idpc);
        rdy = imem_ready;
        rd  = imem_rdata;
        if (!rst_n) begin
          model_reset();
        end else if (m_boot) begin
          m_boot = 1'b0;
        end else if (branch_taken) begin
          m_infl  = e_req && !rdy;
          m_drop  = m_infl;
          m_iaddr = e_addr;
          m_pc    = {branch_target[31:2], 2'b00};
          m_idv   = 1'b0;
          m_idi   = NOP;
          m_skid  = 1'b0;
        end else if (m_infl && m_drop) begin
          if (rdy) begin m_infl = 1'b0; m_drop = 1'b0; end
        end else if (stall) begin
          if (e_req && rdy) begin
            m_skid = 1'b1; m_skw = rd; m_infl = 1'b0;
          end else begin
            m_infl = e_req; m_iaddr = m_pc;
          end
        end else if (m_skid) begin
          m_idv = 1'b1; m_idi = m_skw; m_idpc = m_pc; m_pc = m_pc + 32'd4; m_skid = 1'b0;
        end else if (e_req && rdy) begin
          m_idv = 1'b1; m_idi = rd; m_idpc = m_pc; m_pc = m_pc + 32'd4; m_infl = 1'b0;
        end else begin
          m_idv = 1'b0; m_idi = NOP; m_infl = e_req; m_iaddr = m_pc;
        end
        @(negedge clk);
      end
    end

`ifdef IF_MISALIGN_TRAP_EN
    // Misaligned redirect while a fetch is outstanding: wait it out, then halt
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, GARB);
    chk("trap.reset_err", 32'(misalign_err), 32'h0);
    @(negedge clk);
    step(1'b0, 1'b1, 32'h102, 1'b0, GARB);
    check_req("trap.issue", 1'b1, 32'h0);
    @(negedge clk);
    step(1'b0, 1'b0, 32'h0, 1'b1, GARB);
    chk("trap.err", 32'(misalign_err), 32'h1);
    check_req("trap.drain", 1'b1, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, GARB);
      check_req("trap.halt", 1'b0, 32'h0);
      check_id("trap.halt", 1'b0, NOP, 32'h0);
      chk("trap.sticky", 32'(misalign_err), 32'h1);
      @(negedge clk);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
